led_activity_ctrl: RTL and testbench

//  Parametrised LED driver that generalises the single inverted SD-activity LED tap.

---
 rtl/led_activity_if.sv | 23 ++
 rtl/led_activity_ctrl.sv | 121 ++++++++++++
 tb/tb_led_activity_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_activity_if.sv
// Activity inputs, static config and LED drives for led_activity_ctrl.
// The master side drives activity and config; the slave side returns LED state.
interface led_activity_if #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PWM_BITS = 8
);
  logic [NUM_CH-1:0]   act_in;
  logic [NUM_CH-1:0]   act_pol;
  logic [2*NUM_CH-1:0] mode;
  logic [PWM_BITS-1:0] brightness;
  logic [NUM_CH-1:0]   led_out;
  logic [NUM_CH-1:0]   led_active;

  modport master (
    output act_in, act_pol, mode, brightness,
    input  led_out, led_active
  );

  modport slave (
    input  act_in, act_pol, mode, brightness,
    output led_out, led_active
  );
endinterface

// File: rtl/led_activity_ctrl.sv
// Multi-channel activity LED driver: synchronise, polarity-correct, pulse-stretch,
// optionally blink, then PWM-dim each activity input onto a registered LED output.
module led_activity_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned STRETCH_MS  = 50,
  parameter int unsigned BLINK_MS    = 100,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset_n,
  led_activity_if.slave bus
);
  localparam int unsigned TickDiv = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  typedef enum logic [1:0] {
    ModeDirect  = 2'b00,
    ModeStretch = 2'b01,
    ModeBlink   = 2'b10,
    ModeOff     = 2'b11
  } mode_e;

  logic [NUM_CH-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]   s, s_q, edge_det, busy, lit;
  logic [15:0]         cnt_q  [NUM_CH];
  logic [15:0]         cnt_d  [NUM_CH];
  logic [15:0]         bcnt_q [NUM_CH];
  logic [15:0]         bcnt_d [NUM_CH];
  logic [NUM_CH-1:0]   blink_off_q, blink_off_d;
  logic [TickW-1:0]    pre_q;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_q;
  logic                dim;
  logic [NUM_CH-1:0]   led_out_q, led_out_d, led_active_q;

  assign tick     = (pre_q == TickW'(TickDiv - 1));
  assign dim      = (&bus.brightness) | (pwm_q < bus.brightness);
  assign s        = sync_q[SYNC_STAGES-1] ^ bus.act_pol;
  assign edge_det = s ^ s_q;

  always_comb begin
    mode_e m;
    m           = ModeDirect;
    busy        = '0;
    lit         = '0;
    blink_off_d = blink_off_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      bcnt_d[i] = bcnt_q[i];
      // A reload on an edge takes priority over a coincident tick decrement.
      if (edge_det[i]) begin
        cnt_d[i] = 16'(STRETCH_MS);
      end else if (tick && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 16'd1;
      end
      busy[i] = (cnt_q[i] != '0) | s[i];

      // blink_off is the inverted phase, so clearing it lights the first period.
      if (!busy[i]) begin
        bcnt_d[i]      = '0;
        blink_off_d[i] = 1'b0;
      end else if (tick) begin
        if (bcnt_q[i] == 16'(BLINK_MS - 1)) begin
          bcnt_d[i]      = '0;
          blink_off_d[i] = ~blink_off_q[i];
        end else begin
          bcnt_d[i] = bcnt_q[i] + 16'd1;
        end
      end

      m = mode_e'(bus.mode[2*i +: 2]);
      unique case (m)
        ModeDirect:  lit[i] = s[i];
        ModeStretch: lit[i] = busy[i];
        ModeBlink:   lit[i] = busy[i] & ~blink_off_q[i];
        ModeOff:     lit[i] = 1'b0;
        default:     lit[i] = 1'b0;
      endcase
    end
  end

  assign led_out_d = lit & {NUM_CH{dim}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        bcnt_q[i] <= '0;
      end
      s_q          <= '0;
      blink_off_q  <= '0;
      pre_q        <= '0;
      pwm_q        <= '0;
      led_out_q    <= '0;
      led_active_q <= '0;
    end else begin
      sync_q[0] <= bus.act_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        bcnt_q[i] <= bcnt_d[i];
      end
      s_q          <= s;
      blink_off_q  <= blink_off_d;
      pre_q        <= tick ? '0 : pre_q + TickW'(1);
      pwm_q        <= pwm_q + PWM_BITS'(1);
      led_out_q    <= led_out_d;
      led_active_q <= lit;
    end
  end

  assign bus.led_out    = led_out_q;
  assign bus.led_active = led_active_q;
endmodule

// File: tb/tb_led_activity_ctrl.sv
// Bench for led_activity_ctrl: timestamp-based model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_led_activity_ctrl;
  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned CLK_HZ      = 10_000;
  localparam int unsigned STRETCH_MS  = 5;
  localparam int unsigned BLINK_MS    = 2;
  localparam int unsigned PWM_BITS    = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int TICK_DIV = 10;
  localparam int SMS      = 5;
  localparam int BMS      = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  led_activity_if #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS)) bus ();

  led_activity_ctrl #(
    .NUM_CH     (NUM_CH),
    .CLK_HZ     (CLK_HZ),
    .STRETCH_MS (STRETCH_MS),
    .BLINK_MS   (BLINK_MS),
    .PWM_BITS   (PWM_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: cyc is the index of the current cycle since reset release.
  int                cyc = 0;
  logic [NUM_CH-1:0] raw_h [4];
  logic [NUM_CH-1:0] s_h   [4];
  int                last_edge  [NUM_CH];
  int                busy_start [NUM_CH];
  bit                busy_prev  [NUM_CH];
  logic [NUM_CH-1:0] exp_out = '0;
  logic [NUM_CH-1:0] exp_act = '0;

  // Number of tick cycles (index % TICK_DIV == TICK_DIV-1) in [a, b].
  function automatic int ticks_in(input int a, input int b);
    if (b < a) return 0;
    return (b + 1) / TICK_DIV - a / TICK_DIV;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: at each edge, derive cycle k's lit/dim from timestamps and inputs.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        cyc     = 0;
        exp_out = '0;
        exp_act = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          last_edge[i]  = -1;
          busy_start[i] = 0;
          busy_prev[i]  = 1'b0;
        end
      end else begin
        int k;
        k = cyc;
        for (int i = 0; i < NUM_CH; i++) begin
          bit r, sv, sd, busy, bl, lit, dim;
          int cnt;
          r   = (k >= 2) ? raw_h[(k - 2) % 4][i] : 1'b0;
          sv  = r ^ bus.act_pol[i];
          sd  = (k >= 1) ? s_h[(k - 1) % 4][i] : 1'b0;
          s_h[k % 4][i] = sv;
          cnt = 0;
          if (last_edge[i] >= 0) begin
            cnt = SMS - ticks_in(last_edge[i] + 1, k - 1);
            if (cnt < 0) cnt = 0;
          end
          if (sv != sd) last_edge[i] = k;
          busy = (cnt != 0) || sv;
          if (busy && !busy_prev[i]) busy_start[i] = k;
          busy_prev[i] = busy;
          bl = busy && (((ticks_in(busy_start[i], k - 1) / BMS) % 2) == 0);
          case (bus.mode[2*i +: 2])
            2'b00:   lit = sv;
            2'b01:   lit = busy;
            2'b10:   lit = bl;
            default: lit = 1'b0;
          endcase
          dim = (bus.brightness == 4'hF) || ((k % 16) < int'(bus.brightness));
          exp_act[i] = lit;
          exp_out[i] = lit && dim;
        end
        raw_h[k % 4] = bus.act_in;
        cyc = k + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (bus.led_out !== exp_out || bus.led_active !== exp_act) begin
        miscompares++;
        $display("FAIL model cycle %0d: led_out=%b want %b, led_active=%b want %b",
                 cyc, bus.led_out, exp_out, bus.led_active, exp_act);
      end
    end
  end

  initial begin
    bus.act_in     = '0;
    bus.act_pol    = '0;
    bus.mode       = '0;
    bus.brightness = 4'hF;

    // 1: reset held with toggling inputs, then quiet release.
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      bus.act_in = ~bus.act_in;
      chk("reset_led_out", int'(bus.led_out), 0);
      chk("reset_led_active", int'(bus.led_active), 0);
    end
    @(negedge clk);
    bus.act_in = '0;
    reset_n    = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step(1);
      chk("idle_after_release", int'({bus.led_out, bus.led_active}), 0);
    end

    // 2: DIRECT, inverted polarity, exactly 3-clock latency both ways.
    bus.act_pol[0] = 1'b1;
    bus.act_in[0]  = 1'b1;
    step(20);
    bus.act_in[0] = 1'b0;
    step(1); chk("direct_on_lat1", int'(bus.led_out[0]), 0);
    step(1); chk("direct_on_lat2", int'(bus.led_out[0]), 0);
    step(1); chk("direct_on_lat3", int'(bus.led_out[0]), 1);
    step(5);
    bus.act_in[0] = 1'b1;
    step(1); chk("direct_off_lat1", int'(bus.led_out[0]), 1);
    step(1); chk("direct_off_lat2", int'(bus.led_out[0]), 1);
    step(1); chk("direct_off_lat3", int'(bus.led_out[0]), 0);

    // 3: STRETCH on ch1, single pulse then a retrigger 30 clocks later.
    bus.mode[3:2] = 2'b01;
    step(80);
    bus.act_in[1] = 1'b1;
    step(1); bus.act_in[1] = 1'b0;
    step(28); chk("stretch_hold_29", int'(bus.led_active[1]), 1);
    step(1);  bus.act_in[1] = 1'b1;
    step(1);  bus.act_in[1] = 1'b0;
    step(43); chk("stretch_retrig_hold", int'(bus.led_active[1]), 1);
    step(12); chk("stretch_retrig_off", int'(bus.led_active[1]), 0);

    // 5: PWM duty with ch1 held busy.
    bus.act_in[1] = 1'b1;
    step(6);
    for (int b = 0; b < 3; b++) begin
      int hi, want;
      bus.brightness = (b == 0) ? 4'd4 : ((b == 1) ? 4'd0 : 4'hF);
      want = (b == 0) ? 8 : ((b == 1) ? 0 : 32);
      step(2);
      hi = 0;
      for (int n = 0; n < 32; n++) begin
        step(1);
        if (bus.led_out[1]) hi++;
      end
      chk("pwm_duty_32", hi, want);
    end

    // 6: edge on a tick cycle while OFF, then switch back to STRETCH mid-count.
    bus.brightness = 4'hF;
    bus.mode[3:2]  = 2'b11;
    step(5);
    for (int n = 0; n < 10 && (cyc % TICK_DIV) != TICK_DIV - 3; n++) step(1);
    chk("tick_align", cyc % TICK_DIV, TICK_DIV - 3);
    bus.act_in[1] = 1'b0;              // s edge lands on cycle m = now+2
    step(7);  chk("off_led_out_a", int'(bus.led_out[1]), 0);
    step(10); chk("off_led_out_b", int'(bus.led_out[1]), 0);
    step(5);  bus.mode[3:2] = 2'b01;   // cycle m+20
    step(1);  chk("resume_lit", int'(bus.led_active[1]), 1);
    step(30); chk("coincide_hold_m51", int'(bus.led_active[1]), 1);
    step(1);  chk("coincide_off_m52", int'(bus.led_active[1]), 0);

    // 4: BLINK on ch0 (inverted input), 26 toggles every 8 clocks.
    bus.mode[1:0] = 2'b10;
    step(80);
    for (int t = 0; t <= 280; t++) begin
      if (t % 8 == 0 && t <= 200) bus.act_in[0] = ~bus.act_in[0];
      step(1);
      if (t + 1 == 2)  chk("blink_pre", int'(bus.led_active[0]), 0);
      if (t + 1 == 3)  chk("blink_first_high", int'(bus.led_active[0]), 1);
      if (t + 1 == 33) chk("blink_low_phase", int'(bus.led_active[0]), 0);
      if (t + 1 == 43) chk("blink_high_phase", int'(bus.led_active[0]), 1);
      if (t + 1 >= 257) chk("blink_quiet", int'(bus.led_active[0]), 0);
    end

    // 7: async reset mid-activity clears everything; nothing carried over.
    bus.act_in[1] = 1'b1;
    step(10);
    chk("pre_reset_lit", int'(bus.led_active[1]), 1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_out", int'({bus.led_out, bus.led_active}), 0);
    bus.act_in  = '0;
    bus.act_pol = '0;
    step(3);
    #2 reset_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      step(1);
      chk("post_reset_idle", int'({bus.led_out, bus.led_active}), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
